mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between two requesters: the fetch stage (read-only) and the data/LSU stage (read/write).

---
 rtl/mem_port_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (read-only) and data (read/write) ports; one access in flight, response MEM_LATENCY cycles after grant.
// Data side wins unless fetch has waited STARVE_LIMIT data grants; ready is combinational in IDLE only. ARB_PERF_CNT_EN adds grant/conflict counters.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req_valid_i,
  input  logic [ADDR_W-1:0] f_req_addr_i,
  output logic              f_req_ready_o,
  output logic              f_rsp_valid_o,
  output logic [DATA_W-1:0] f_rsp_data_o,
  input  logic              d_req_valid_i,
  input  logic [ADDR_W-1:0] d_req_addr_i,
  input  logic              d_req_write_i,
  input  logic [DATA_W-1:0] d_req_wdata_i,
  output logic              d_req_ready_o,
  output logic              d_rsp_valid_o,
  output logic [DATA_W-1:0] d_rsp_data_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  output logic              mem_read_write_o,
  input  logic [DATA_W-1:0] mem_data_out_i
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_f_grants_o,
  output logic [31:0]       perf_d_grants_o,
  output logic [31:0]       perf_conflicts_o
`endif
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              own_f_q, own_f_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] f_data_q, f_data_d;
  logic [DATA_W-1:0] d_data_q, d_data_d;
  logic              grant_f, grant_d;

  always_comb begin
    state_d          = state_q;
    lat_d            = lat_q;
    starve_d         = starve_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    own_f_d          = own_f_q;
    write_d          = write_q;
    f_data_d         = f_data_q;
    d_data_d         = d_data_q;
    grant_f          = 1'b0;
    grant_d          = 1'b0;
    f_rsp_valid_o    = 1'b0;
    d_rsp_valid_o    = 1'b0;
    f_rsp_data_o     = f_data_q;
    d_rsp_data_o     = d_data_q;
    mem_address_o    = addr_q;
    mem_data_in_o    = wdata_q;
    mem_read_write_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_req_valid_i && !(f_req_valid_i && starve_q == STV_MAX)) grant_d = 1'b1;
        else if (f_req_valid_i)                                        grant_f = 1'b1;
        if (grant_f || grant_d) begin
          state_d       = BUSY;
          lat_d         = LAT_W'(1);
          own_f_d       = grant_f;
          write_d       = grant_d && d_req_write_i;
          addr_d        = grant_f ? f_req_addr_i : d_req_addr_i;
          mem_address_o = grant_f ? f_req_addr_i : d_req_addr_i;
        end
        if (grant_d && d_req_write_i) begin
          wdata_d          = d_req_wdata_i;
          mem_data_in_o    = d_req_wdata_i;
          mem_read_write_o = 1'b1;
        end
      end
      BUSY: begin
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
          if (own_f_q) begin
            f_rsp_valid_o = 1'b1;
            f_rsp_data_o  = mem_data_out_i;
            f_data_d      = mem_data_out_i;
          end else begin
            d_rsp_valid_o = 1'b1;
            d_rsp_data_o  = write_q ? '0 : mem_data_out_i;
            d_data_d      = write_q ? '0 : mem_data_out_i;
          end
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    f_req_ready_o = grant_f;
    d_req_ready_o = grant_d;

    // Starvation count only grows while fetch is actually waiting.
    if (!f_req_valid_i || grant_f)          starve_d = '0;
    else if (grant_d && starve_q != STV_MAX) starve_d = starve_q + STV_W'(1);

    if (reset) begin
      f_req_ready_o    = 1'b0;
      d_req_ready_o    = 1'b0;
      f_rsp_valid_o    = 1'b0;
      d_rsp_valid_o    = 1'b0;
      mem_address_o    = '0;
      mem_data_in_o    = '0;
      mem_read_write_o = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      lat_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      own_f_q  <= 1'b0;
      write_q  <= 1'b0;
      f_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      own_f_q  <= own_f_d;
      write_q  <= write_d;
      f_data_q <= f_data_d;
      d_data_q <= d_data_d;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_f_q, perf_d_q, perf_c_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_f_q <= '0;
      perf_d_q <= '0;
      perf_c_q <= '0;
    end else begin
      if (grant_f) perf_f_q <= perf_f_q + 32'd1;
      if (grant_d) perf_d_q <= perf_d_q + 32'd1;
      if (state_q == IDLE && f_req_valid_i && d_req_valid_i) perf_c_q <= perf_c_q + 32'd1;
    end
  end

  assign perf_f_grants_o  = perf_f_q;
  assign perf_d_grants_o  = perf_d_q;
  assign perf_conflicts_o = perf_c_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 3) driven side by side and checked each cycle
// against a transaction-level model of grants, response timing, memory contents and held response data.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int M_HOLD = 0, M_ONE = 1, M_RAND = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]  rst, f_vld, f_rdy, f_rv, d_vld, d_wr, d_rdy, d_rv, m_rw;
  logic [31:0] f_addr [2], f_rd [2], d_addr [2], d_wd [2], d_rd [2];
  logic [31:0] m_addr [2], m_din [2], m_dout [2];
  logic [31:0] emem [2][256];

  assign m_dout[0] = emem[0][m_addr[0][9:2]];
  assign m_dout[1] = emem[1][m_addr[1][9:2]];

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(LIM)) u_dut_l1 (
    .clock(clock), .reset(rst[0]),
    .f_req_valid_i(f_vld[0]), .f_req_addr_i(f_addr[0]), .f_req_ready_o(f_rdy[0]),
    .f_rsp_valid_o(f_rv[0]), .f_rsp_data_o(f_rd[0]),
    .d_req_valid_i(d_vld[0]), .d_req_addr_i(d_addr[0]), .d_req_write_i(d_wr[0]),
    .d_req_wdata_i(d_wd[0]), .d_req_ready_o(d_rdy[0]),
    .d_rsp_valid_o(d_rv[0]), .d_rsp_data_o(d_rd[0]),
    .mem_address_o(m_addr[0]), .mem_data_in_o(m_din[0]), .mem_read_write_o(m_rw[0]),
    .mem_data_out_i(m_dout[0]));

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(LIM)) u_dut_l3 (
    .clock(clock), .reset(rst[1]),
    .f_req_valid_i(f_vld[1]), .f_req_addr_i(f_addr[1]), .f_req_ready_o(f_rdy[1]),
    .f_rsp_valid_o(f_rv[1]), .f_rsp_data_o(f_rd[1]),
    .d_req_valid_i(d_vld[1]), .d_req_addr_i(d_addr[1]), .d_req_write_i(d_wr[1]),
    .d_req_wdata_i(d_wd[1]), .d_req_ready_o(d_rdy[1]),
    .d_rsp_valid_o(d_rv[1]), .d_rsp_data_o(d_rd[1]),
    .mem_address_o(m_addr[1]), .mem_data_in_o(m_din[1]), .mem_read_write_o(m_rw[1]),
    .mem_data_out_i(m_dout[1]));

  // Reference model state: one outstanding access per instance, tracked by cycle numbers.
  int          lat [2] = '{1, 3};
  int          cyc, mode;
  int          free_at [2], starve [2], o_cyc [2], n_fgr [2], n_drv [2];
  bit          o_f [2], o_wr [2], acc_f [2], acc_d [2], wr_en [2];
  logic [31:0] o_addr [2], o_wd [2], last_f [2], last_d [2], wr_a [2], wr_d [2];
  logic [31:0] rmem [2][256];
  int          n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int winner(input int i);
    if (cyc < free_at[i]) return 0;
    if (d_vld[i] && !(f_vld[i] && starve[i] == LIM)) return 2;
    if (f_vld[i]) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] rsp_value(input int i);
    return o_wr[i] ? 32'h0 : rmem[i][o_addr[i][9:2]];
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h0100_0000 + ($urandom_range(0, 15) << 2);
  endfunction

  task automatic check_inst(input int i);
    int    win;
    string p;
    p = $sformatf("L%0d", lat[i]);
    if (f_rdy[i]) n_fgr[i]++;
    if (d_rv[i])  n_drv[i]++;
    wr_en[i] = 1'b0;
    if (rst[i]) begin
      chk({p, "_rst_f_ready"}, f_rdy[i], 0);
      chk({p, "_rst_d_ready"}, d_rdy[i], 0);
      chk({p, "_rst_f_rsp_valid"}, f_rv[i], 0);
      chk({p, "_rst_d_rsp_valid"}, d_rv[i], 0);
      chk({p, "_rst_mem_rw"}, m_rw[i], 0);
      chk({p, "_rst_mem_address"}, m_addr[i], 0);
      chk({p, "_rst_mem_data_in"}, m_din[i], 0);
      return;
    end
    win = winner(i);
    chk({p, "_f_ready"}, f_rdy[i], win == 1);
    chk({p, "_d_ready"}, d_rdy[i], win == 2);
    chk({p, "_mem_rw"}, m_rw[i], win == 2 && d_wr[i]);
    if (win == 1) chk({p, "_issue_addr_f"}, m_addr[i], f_addr[i]);
    if (win == 2) chk({p, "_issue_addr_d"}, m_addr[i], d_addr[i]);
    if (win == 2 && d_wr[i]) chk({p, "_issue_wdata"}, m_din[i], d_wd[i]);
    if (cyc < free_at[i]) begin
      chk({p, "_hold_addr"}, m_addr[i], o_addr[i]);
      if (o_wr[i]) chk({p, "_hold_wdata"}, m_din[i], o_wd[i]);
    end
    if (o_cyc[i] == cyc) begin
      chk({p, "_f_rsp_valid"}, f_rv[i], o_f[i]);
      chk({p, "_d_rsp_valid"}, d_rv[i], !o_f[i]);
      chk({p, "_f_rsp_data"}, f_rd[i], o_f[i] ? rsp_value(i) : last_f[i]);
      chk({p, "_d_rsp_data"}, d_rd[i], o_f[i] ? last_d[i] : rsp_value(i));
    end else begin
      chk({p, "_f_rsp_valid_idle"}, f_rv[i], 0);
      chk({p, "_d_rsp_valid_idle"}, d_rv[i], 0);
      chk({p, "_f_rsp_data_hold"}, f_rd[i], last_f[i]);
      chk({p, "_d_rsp_data_hold"}, d_rd[i], last_d[i]);
    end
    wr_en[i] = m_rw[i];
    wr_a[i]  = m_addr[i];
    wr_d[i]  = m_din[i];
  endtask

  task automatic update(input int i);
    int win;
    if (wr_en[i]) emem[i][wr_a[i][9:2]] = wr_d[i];
    acc_f[i] = 1'b0;
    acc_d[i] = 1'b0;
    if (rst[i]) begin
      free_at[i] = cyc + 1;
      starve[i]  = 0;
      o_cyc[i]   = -1;
      last_f[i]  = 32'h0;
      last_d[i]  = 32'h0;
      return;
    end
    win = winner(i);
    acc_f[i] = (win == 1);
    acc_d[i] = (win == 2);
    if (o_cyc[i] == cyc) begin
      if (o_f[i]) last_f[i] = rsp_value(i);
      else        last_d[i] = rsp_value(i);
      o_cyc[i] = -1;
    end
    if (!f_vld[i] || win == 1)         starve[i] = 0;
    else if (win == 2 && starve[i] < LIM) starve[i]++;
    if (win != 0) begin
      o_cyc[i]   = cyc + lat[i];
      free_at[i] = cyc + lat[i] + 1;
      o_f[i]     = (win == 1);
      o_wr[i]    = (win == 2) && d_wr[i];
      o_addr[i]  = (win == 1) ? f_addr[i] : d_addr[i];
      o_wd[i]    = d_wd[i];
      if (o_wr[i]) rmem[i][o_addr[i][9:2]] = d_wd[i];
    end
  endtask

  task automatic drive(input int i);
    case (mode)
      M_ONE: begin
        if (acc_f[i]) f_vld[i] = 1'b0;
        if (acc_d[i]) d_vld[i] = 1'b0;
      end
      M_RAND: begin
        if (!f_vld[i] || acc_f[i]) begin
          f_vld[i]  = ($urandom_range(0, 99) < 50);
          f_addr[i] = rand_addr();
        end else if ($urandom_range(0, 99) < 5) f_vld[i] = 1'b0;
        if (!d_vld[i] || acc_d[i]) begin
          d_vld[i]  = ($urandom_range(0, 99) < 60);
          d_addr[i] = rand_addr();
          d_wr[i]   = ($urandom_range(0, 2) == 0);
          d_wd[i]   = $urandom;
        end else if ($urandom_range(0, 99) < 5) d_vld[i] = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(negedge clock);
    for (int i = 0; i < 2; i++) check_inst(i);
    @(posedge clock);
    for (int i = 0; i < 2; i++) update(i);
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) drive(i);
  endtask

  task automatic set_all(input logic fv, input logic dv, input logic [31:0] fa,
                         input logic [31:0] da, input logic dw, input logic [31:0] wd);
    f_vld = {fv, fv};
    d_vld = {dv, dv};
    d_wr  = {dw, dw};
    for (int i = 0; i < 2; i++) begin
      f_addr[i] = fa;
      d_addr[i] = da;
      d_wd[i]   = wd;
    end
  endtask

  initial begin
    int b0, b1;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    mode  = M_HOLD;
    for (int i = 0; i < 2; i++) begin
      free_at[i] = 0; starve[i] = 0; o_cyc[i] = -1; n_fgr[i] = 0; n_drv[i] = 0;
      last_f[i] = 32'h0; last_d[i] = 32'h0; o_addr[i] = 32'h0; o_wd[i] = 32'h0;
      for (int w = 0; w < 256; w++) begin
        emem[i][w] = (w == 0) ? 32'h0000_0013 : (32'h5A5A_0000 ^ (w * 32'h0101_0101));
        rmem[i][w] = emem[i][w];
      end
    end

    // Reset held with both requesters asserting: nothing may leak out.
    rst = 2'b11;
    set_all(1'b1, 1'b1, 32'h0100_0000, 32'h0100_0100, 1'b1, 32'h1234_5678);
    repeat (3) cycle();
    rst = 2'b00;

    // Fetch-only stream from the reset vector.
    set_all(1'b1, 1'b0, 32'h0100_0000, 32'h0, 1'b0, 32'h0);
    repeat (8) cycle();
    chk("t2_fetch_data_L1", f_rd[0], 32'h0000_0013);
    chk("t2_fetch_data_L3", f_rd[1], 32'h0000_0013);

    // Simultaneous requests: data first, then fetch.
    set_all(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (4) cycle();
    mode = M_ONE;
    set_all(1'b1, 1'b1, 32'h0100_0000, 32'h0100_0100, 1'b0, 32'h0);
    repeat (10) cycle();

    // Both held continuously: fetch forced after every LIM data grants.
    mode = M_HOLD;
    b0 = n_fgr[0];
    b1 = n_fgr[1];
    set_all(1'b1, 1'b1, 32'h0100_0004, 32'h0100_0008, 1'b0, 32'h0);
    repeat (40) cycle();
    chk("t4_f_grants_L1", n_fgr[0] - b0, 4);
    chk("t4_f_grants_L3", n_fgr[1] - b1, 2);

    // Store then readback.
    set_all(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (6) cycle();
    mode = M_ONE;
    set_all(1'b0, 1'b1, 32'h0, 32'h0100_0200, 1'b1, 32'hDEAD_BEEF);
    repeat (6) cycle();
    set_all(1'b0, 1'b1, 32'h0, 32'h0100_0200, 1'b0, 32'h0);
    repeat (6) cycle();
    chk("t5_readback_L1", d_rd[0], 32'hDEAD_BEEF);
    chk("t5_readback_L3", d_rd[1], 32'hDEAD_BEEF);

    // Reset in the middle of a latency-3 load.
    repeat (2) cycle();
    set_all(1'b0, 1'b1, 32'h0, 32'h0100_0004, 1'b0, 32'h0);
    cycle();
    b1 = n_drv[1];
    rst[1] = 1'b1;
    cycle();
    rst[1]    = 1'b0;
    d_vld[1]  = 1'b1;
    d_addr[1] = 32'h0100_0008;
    repeat (8) cycle();
    chk("t6_rsp_count_after_reset", n_drv[1] - b1, 1);

    // Randomized traffic.
    mode = M_RAND;
    repeat (3000) cycle();
    mode = M_ONE;
    set_all(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
